regfile_wb_sink: RTL and testbench

//  Receiving end of the writeback interface: 32x32 register file that accepts

---
 rtl/regfile_wb_sink_if.sv | 14 +
 rtl/regfile_wb_sink.sv | 91 +++++++++
 tb/tb_regfile_wb_sink.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_sink_if.sv
// Writeback bus from the writeBack stage into the register file.
// The writeBack stage drives it through the master modport.
// The register file receives it through the slave modport.
interface regfile_wb_sink_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              RegWriteW;
  logic [ADDR_W-1:0] WriteRegW;
  logic [DATA_W-1:0] ResultW;

  modport master (output RegWriteW, output WriteRegW, output ResultW);
  modport slave  (input  RegWriteW, input  WriteRegW, input  ResultW);
endinterface

// File: rtl/regfile_wb_sink.sv
// Register file with two combinational read ports and a per-register
// pending-write scoreboard. The scoreboard stalls decode while an issued
// write has not yet come back through writeback.
// Optional macro REGFILE_WB_BYPASS_EN forwards the writeback value to the
// read ports and clears a stall in the cycle the final outstanding write lands.
module regfile_wb_sink #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_sink_if.slave    wb,
  input  logic [ADDR_W-1:0]   A1D,
  input  logic [ADDR_W-1:0]   A2D,
  output logic [DATA_W-1:0]   RD1D,
  output logic [DATA_W-1:0]   RD2D,
  input  logic                issueD,
  input  logic [ADDR_W-1:0]   issueRegD,
  output logic                stallD,
  output logic                sbErr
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [CNT_W-1:0]  cnt_q  [NREGS];
  logic [CNT_W-1:0]  cnt_d  [NREGS];
  logic              sbErr_q, sbErr_d;
  logic              wb_hit;
  logic              issue_ok;
  logic              pend1, pend2;

  assign wb_hit   = wb.RegWriteW && (wb.WriteRegW != '0);
  assign issue_ok = issueD && !stallD && (issueRegD != '0);
  assign sbErr    = sbErr_q;

  // Read ports and operand-pending detection
  always_comb begin
    RD1D  = (A1D == '0) ? '0 : regs_q[A1D];
    RD2D  = (A2D == '0) ? '0 : regs_q[A2D];
    pend1 = (A1D != '0) && (cnt_q[A1D] != '0);
    pend2 = (A2D != '0) && (cnt_q[A2D] != '0);
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_hit && (wb.WriteRegW == A1D)) begin
      RD1D = wb.ResultW;
      if (cnt_q[A1D] == CNT_W'(1)) pend1 = 1'b0;
    end
    if (wb_hit && (wb.WriteRegW == A2D)) begin
      RD2D = wb.ResultW;
      if (cnt_q[A2D] == CNT_W'(1)) pend2 = 1'b0;
    end
`endif
    stallD = pend1 || pend2;
  end

  // Scoreboard next state: issue increments, writeback decrements, both cancel
  always_comb begin
    sbErr_d = sbErr_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      logic [ADDR_W-1:0] idx;
      logic              inc, dec;
      idx      = ADDR_W'(i);
      cnt_d[i] = cnt_q[i];
      inc      = issue_ok && (issueRegD == idx);
      dec      = wb_hit && (wb.WriteRegW == idx);
      if (inc && !dec) begin
        if (cnt_q[i] == '1) sbErr_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        if (cnt_q[i] == '0) sbErr_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Register storage, counters and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      sbErr_q <= 1'b0;
    end else begin
      if (wb_hit) regs_q[wb.WriteRegW] <= wb.ResultW;
      for (int unsigned i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
      sbErr_q <= sbErr_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed bench for regfile_wb_sink; expectations follow REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_sink;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  A1D, A2D, issueRegD;
  logic        issueD;
  logic [31:0] RD1D, RD2D;
  logic        stallD, sbErr;
  int          errors = 0;
  int          checks = 0;

  regfile_wb_sink_if #(.DATA_W(32), .ADDR_W(5)) wb ();

  regfile_wb_sink #(.DATA_W(32), .NREGS(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .wb(wb),
    .A1D(A1D), .A2D(A2D), .RD1D(RD1D), .RD2D(RD2D),
    .issueD(issueD), .issueRegD(issueRegD),
    .stallD(stallD), .sbErr(sbErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge and return just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.RegWriteW = 1'b0; wb.WriteRegW = '0; wb.ResultW = '0;
    issueD = 1'b0; issueRegD = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    A1D = '0; A2D = '0;
    do_reset();

    // 1. reset state on every address
    for (int a = 0; a < 32; a++) begin
      A1D = 5'(a); A2D = 5'(31 - a);
      #1;
      chk("rst_rd1", RD1D, 32'h0);
      chk("rst_rd2", RD2D, 32'h0);
      chk("rst_stall", {31'b0, stallD}, 32'h0);
    end
    chk("rst_sberr", {31'b0, sbErr}, 32'h0);

    // 2. plain write then read; r0 write ignored
    A1D = '0; A2D = '0;
    wb.RegWriteW = 1'b1; wb.WriteRegW = 5'd5; wb.ResultW = 32'hDEADBEEF;
    tick();
    idle(); A1D = 5'd5;
    #1;
    chk("wr_r5", RD1D, 32'hDEADBEEF);
    chk("wr_unissued_sberr", {31'b0, sbErr}, 32'h1);
    wb.RegWriteW = 1'b1; wb.WriteRegW = 5'd0; wb.ResultW = 32'h1234;
    tick();
    idle(); A1D = '0; A2D = '0;
    #1;
    chk("r0_rd1", RD1D, 32'h0);
    chk("r0_rd2", RD2D, 32'h0);

    // 3. RAW stall on r7
    do_reset();
    A1D = '0;
    issueD = 1'b1; issueRegD = 5'd7;
    #1;
    chk("iss7_nostall", {31'b0, stallD}, 32'h0);
    tick();
    idle(); A1D = 5'd7;
    #1;
    chk("r7_pend_a", {31'b0, stallD}, 32'h1);
    tick();
    chk("r7_pend_b", {31'b0, stallD}, 32'h1);
    wb.RegWriteW = 1'b1; wb.WriteRegW = 5'd7; wb.ResultW = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("r7_wb_stall", {31'b0, stallD}, 32'h0);
    chk("r7_wb_rd", RD1D, 32'hA5A5A5A5);
`else
    chk("r7_wb_stall", {31'b0, stallD}, 32'h1);
    chk("r7_wb_rd", RD1D, 32'h0);
`endif
    tick();
    idle();
    #1;
    chk("r7_after_stall", {31'b0, stallD}, 32'h0);
    chk("r7_after_rd", RD1D, 32'hA5A5A5A5);
    chk("r7_sberr", {31'b0, sbErr}, 32'h0);

    // 4. saturation of r3 counter
    do_reset();
    A1D = '0; A2D = '0;
    for (int k = 0; k < 3; k++) begin
      issueD = 1'b1; issueRegD = 5'd3;
      tick();
    end
    idle();
    #1;
    chk("r3_3_sberr", {31'b0, sbErr}, 32'h0);
    A1D = 5'd3;
    #1;
    chk("r3_3_stall", {31'b0, stallD}, 32'h1);
    A1D = '0;
    issueD = 1'b1; issueRegD = 5'd3;
    tick();
    idle();
    #1;
    chk("r3_ovf_sberr", {31'b0, sbErr}, 32'h1);
    A1D = 5'd3;
    for (int k = 0; k < 3; k++) begin
      wb.RegWriteW = 1'b1; wb.WriteRegW = 5'd3; wb.ResultW = 32'(k + 1);
      tick();
      idle();
      #1;
      chk("r3_drain_stall", {31'b0, stallD}, (k == 2) ? 32'h0 : 32'h1);
    end
    chk("r3_val", RD1D, 32'h3);

    // 5. simultaneous issue and writeback on r9; issue while stalled ignored
    do_reset();
    A1D = '0; A2D = '0;
    issueD = 1'b1; issueRegD = 5'd9;
    tick();
    idle();
    issueD = 1'b1; issueRegD = 5'd9;
    wb.RegWriteW = 1'b1; wb.WriteRegW = 5'd9; wb.ResultW = 32'h99;
    tick();
    idle(); A2D = 5'd9;
    #1;
    chk("r9_same_cycle", {31'b0, stallD}, 32'h1);
    chk("r9_same_sberr", {31'b0, sbErr}, 32'h0);
    issueD = 1'b1; issueRegD = 5'd9;
    tick();
    idle();
    wb.RegWriteW = 1'b1; wb.WriteRegW = 5'd9; wb.ResultW = 32'h77;
    tick();
    idle();
    #1;
    chk("r9_ignored_issue", {31'b0, stallD}, 32'h0);
    chk("r9_val", RD2D, 32'h77);
    chk("r9_sberr", {31'b0, sbErr}, 32'h0);

    // 6. mid-operation reset drops in-flight writes
    A2D = '0;
    issueD = 1'b1; issueRegD = 5'd4;
    tick();
    idle();
    wb.RegWriteW = 1'b1; wb.WriteRegW = 5'd4; wb.ResultW = 32'h55;
    tick();
    idle();
    for (int k = 0; k < 2; k++) begin
      issueD = 1'b1; issueRegD = 5'd4;
      tick();
    end
    idle(); A1D = 5'd4;
    #1;
    chk("r4_pend", {31'b0, stallD}, 32'h1);
    chk("r4_val", RD1D, 32'h55);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("r4_rst_stall", {31'b0, stallD}, 32'h0);
    chk("r4_rst_rd", RD1D, 32'h0);
    chk("r4_rst_sberr", {31'b0, sbErr}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
